// File: rtl/spi_sclk_gen.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sclk_gen
//  Description : SPI serial-clock generator with transfer framing. On an
//                accepted start it emits exactly nbits SCLK periods at a
//                half-period of (div+1) clk cycles, in any CPOL/CPHA mode,
//                together with clk-domain sample/shift strobes so the SPI
//                master shift register runs synchronously to clk.
//
//  Ports       : clk         system clock
//                rst         asynchronous active-high reset
//                start       transfer request (only looked at in IDLE)
//                div         SCLK half-period minus one, in clk cycles
//                cpol        SCLK idle level
//                cpha        0: sample on leading edge, 1: shift on leading
//                nbits       bits per transfer (0 suppresses start)
//                sclk        registered SPI serial clock
//                busy        transfer in progress
//                done        one-cycle end-of-transfer pulse
//                sample_stb  master samples MISO in this cycle
//                shift_stb   master drives the next MOSI bit in this cycle
//                bit_idx     sample strobes issued in the current transfer
//
//  Revision    : 1.0  initial release
// ============================================================================
module spi_sclk_gen #(
    parameter int DIV_W  = 8,
    parameter int BITS_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIV_W-1:0]  div,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [BITS_W-1:0] nbits,
    output logic              sclk,
    output logic              busy,
    output logic              done,
    output logic              sample_stb,
    output logic              shift_stb,
    output logic [BITS_W-1:0] bit_idx
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_GUARD = 2'd2;

    localparam logic [DIV_W-1:0]  c_HC_ONE  = DIV_W'(1);
    localparam logic [BITS_W:0]   c_EC_ONE  = (BITS_W+1)'(1);
    localparam logic [BITS_W-1:0] c_BIT_ONE = BITS_W'(1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [DIV_W-1:0]  r_hc;        // clk cycles within current half-period
    logic [BITS_W:0]   r_ec;        // SCLK edges issued so far
    logic [DIV_W-1:0]  r_div;       // configuration latched at start
    logic              r_cpol;
    logic              r_cpha;
    logic [BITS_W-1:0] r_nbits;
    logic              r_sclk;
    logic              r_busy;
    logic              r_done;
    logic              r_sample;
    logic              r_shift;
    logic [BITS_W-1:0] r_bit_idx;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [1:0]        w_state_nxt;
    logic              w_accept;
    logic              w_hc_hit;
    logic [BITS_W:0]   w_ec_last;
    logic              w_last_edge;
    logic              w_leading;
    logic              w_edge_sample;
    logic              w_edge_shift;

    logic [DIV_W-1:0]  w_hc_nxt;
    logic [BITS_W:0]   w_ec_nxt;
    logic              w_sclk_nxt;
    logic              w_done_nxt;
    logic              w_sample_nxt;
    logic              w_shift_nxt;
    logic [BITS_W-1:0] w_bit_idx_nxt;

    // A zero-length transfer is not a transfer at all: start is dropped.
    assign w_accept    = start && (nbits != '0);

    // Half-period boundary: the next clk edge is an SCLK edge (RUN) or
    // the end of the guard interval (GUARD).
    assign w_hc_hit    = (r_hc == r_div);

    // Edge index of the final edge is 2*nbits-1; the extra ec bit keeps
    // this from overflowing at the largest legal nbits.
    assign w_ec_last   = {r_nbits, 1'b0} - c_EC_ONE;
    assign w_last_edge = (r_ec == w_ec_last);

    // Even edge index = leading edge of an SCLK period.
    assign w_leading   = ~r_ec[0];

    // Strobe classification of the edge about to be issued.
    // With cpha=0 bit 0 is already on MOSI when busy rises, so the
    // trailing edge of the last bit must not request another shift.
    always_comb begin
        w_edge_sample = 1'b0;
        w_edge_shift  = 1'b0;
        if (r_cpha) begin
            w_edge_shift  = w_leading;
            w_edge_sample = ~w_leading;
        end else begin
            w_edge_sample = w_leading;
            w_edge_shift  = ~w_leading && ~w_last_edge;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = c_RUN;
                end
            end
            c_RUN: begin
                if (w_hc_hit && w_last_edge) begin
                    w_state_nxt = c_GUARD;
                end
            end
            c_GUARD: begin
                if (w_hc_hit) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / datapath next values (all outputs are registered)
    // ------------------------------------------------------------------
    always_comb begin
        w_hc_nxt      = r_hc;
        w_ec_nxt      = r_ec;
        w_sclk_nxt    = r_sclk;
        w_done_nxt    = 1'b0;
        w_sample_nxt  = 1'b0;
        w_shift_nxt   = 1'b0;
        w_bit_idx_nxt = r_bit_idx;

        case (r_state)
            c_IDLE: begin
                // Track the live cpol so the line idles correctly even
                // before the first transfer.
                w_sclk_nxt = cpol;
                if (w_accept) begin
                    w_hc_nxt      = '0;
                    w_ec_nxt      = '0;
                    w_bit_idx_nxt = '0;
                end
            end
            c_RUN: begin
                if (w_hc_hit) begin
                    w_sclk_nxt   = ~r_sclk;
                    w_hc_nxt     = '0;
                    w_ec_nxt     = r_ec + c_EC_ONE;
                    w_sample_nxt = w_edge_sample;
                    w_shift_nxt  = w_edge_shift;
                    if (w_edge_sample) begin
                        w_bit_idx_nxt = r_bit_idx + c_BIT_ONE;
                    end
                end else begin
                    w_hc_nxt = r_hc + c_HC_ONE;
                end
            end
            c_GUARD: begin
                // Final half-period at the idle level before releasing.
                w_sclk_nxt = r_cpol;
                if (w_hc_hit) begin
                    w_done_nxt = 1'b1;
                    w_hc_nxt   = '0;
                end else begin
                    w_hc_nxt = r_hc + c_HC_ONE;
                end
            end
            default: begin
                w_sclk_nxt = cpol;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hc      <= '0;
            r_ec      <= '0;
            r_sclk    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sample  <= 1'b0;
            r_shift   <= 1'b0;
            r_bit_idx <= '0;
        end else begin
            r_hc      <= w_hc_nxt;
            r_ec      <= w_ec_nxt;
            r_sclk    <= w_sclk_nxt;
            r_busy    <= (w_state_nxt != c_IDLE);
            r_done    <= w_done_nxt;
            r_sample  <= w_sample_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_idx <= w_bit_idx_nxt;
        end
    end

    // Configuration is captured only on an accepted start, so changes to
    // the inputs during a transfer cannot disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div   <= '0;
            r_cpol  <= 1'b0;
            r_cpha  <= 1'b0;
            r_nbits <= '0;
        end else if ((r_state == c_IDLE) && w_accept) begin
            r_div   <= div;
            r_cpol  <= cpol;
            r_cpha  <= cpha;
            r_nbits <= nbits;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sclk       = r_sclk;
    assign busy       = r_busy;
    assign done       = r_done;
    assign sample_stb = r_sample;
    assign shift_stb  = r_shift;
    assign bit_idx    = r_bit_idx;

endmodule
`default_nettype wire

// File: tb/tb_spi_sclk_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_sclk_gen
//  Description : Self-checking bench for spi_sclk_gen. Expected per-cycle
//                output vectors are computed from the timing equations and
//                queued when a transfer is launched, then popped and
//                compared cycle by cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_sclk_gen;

    typedef struct packed {
        logic       sclk;
        logic       busy;
        logic       done;
        logic       smp;
        logic       shf;
        logic [5:0] idx;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] div;
    logic       cpol;
    logic       cpha;
    logic [5:0] nbits;
    logic       sclk;
    logic       busy;
    logic       done;
    logic       sample_stb;
    logic       shift_stb;
    logic [5:0] bit_idx;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    spi_sclk_gen #(.DIV_W(8), .BITS_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .div        (div),
        .cpol       (cpol),
        .cpha       (cpha),
        .nbits      (nbits),
        .sclk       (sclk),
        .busy       (busy),
        .done       (done),
        .sample_stb (sample_stb),
        .shift_stb  (shift_stb),
        .bit_idx    (bit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs c clk edges after the edge that accepted start.
    // Edge k of SCLK lands at c=(k+1)(d+1); done is visible at c=(2n+1)(d+1).
    function automatic exp_t model(input int c, input int d, input bit pol,
                                   input bit pha, input int n);
        exp_t e;
        int   p;
        int   bl;
        int   m;
        int   k;
        bit   lead;
        e  = '0;
        p  = d + 1;
        bl = (2*n + 1) * p;
        m  = c / p;
        if (m > 2*n) m = 2*n;
        e.sclk = pol ^ m[0];
        e.busy = (c < bl);
        e.done = (c == bl);
        if ((c % p == 0) && (c / p >= 1) && (c / p <= 2*n)) begin
            k    = c / p - 1;
            lead = (k % 2 == 0);
            if (pha) begin
                e.shf = lead;
                e.smp = !lead;
            end else begin
                e.smp = lead;
                e.shf = !lead && (k != 2*n - 1);
            end
        end
        e.idx = pha ? 6'(m / 2) : 6'((m + 1) / 2);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t observe();
        exp_t o;
        o.sclk = sclk;
        o.busy = busy;
        o.done = done;
        o.smp  = sample_stb;
        o.shf  = shift_stb;
        o.idx  = bit_idx;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch a transfer and compare every cycle until one IDLE cycle after
    // done. chg: disturb config and re-pulse start mid-transfer.
    // ghost: assert start so it is sampled on the edge that raises done.
    task automatic run_xfer(input string name, input int d, input bit pol,
                            input bit pha, input int n, input bit chg,
                            input bit ghost);
        int   bl;
        int   ns;
        int   nsh;
        exp_t e;
        bl    = (2*n + 1) * (d + 1);
        ns    = 0;
        nsh   = 0;
        div   = d[7:0];
        cpol  = pol;
        cpha  = pha;
        nbits = n[5:0];
        start = 1'b1;
        for (int c = 0; c <= bl; c++) sb_q.push_back(model(c, d, pol, pha, n));
        tick();
        start = 1'b0;
        for (int c = 0; c <= bl; c++) begin
            if (c > 0) tick();
            e = sb_q.pop_front();
            check($sformatf("%s c=%0d", name, c), 32'(observe()), 32'(e));
            ns  += int'(sample_stb);
            nsh += int'(shift_stb);
            if (chg && c == 5) begin
                div   = 8'd7;
                cpol  = ~cpol;
                start = 1'b1;
            end
            if (chg && c == 6) start = 1'b0;
            if (ghost && c == bl - 1) start = 1'b1;
            if (ghost && c == bl) start = 1'b0;
        end
        tick();
        check({name, " idle_busy"}, 32'(busy), 32'(0));
        check({name, " idle_done"}, 32'(done), 32'(0));
        check({name, " idle_sclk"}, 32'(sclk), 32'(cpol));
        check({name, " idle_idx"},  32'(bit_idx), 32'(n));
        check({name, " n_sample"},  32'(ns), 32'(n));
        check({name, " n_shift"},   32'(nsh), pha ? 32'(n) : 32'(n - 1));
    endtask

    initial begin
        exp_t e;
        rst   = 1'b1;
        start = 1'b0;
        div   = 8'd0;
        cpol  = 1'b1;
        cpha  = 1'b0;
        nbits = 6'd0;

        // Reset with cpol=1 held in IDLE.
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("reset c=%0d", i), 32'(observe()), 32'(0));
        end
        rst = 1'b0;
        tick();
        e = '0;
        e.sclk = 1'b1;
        check("post_reset", 32'(observe()), 32'(e));

        // Mode 0, div=3, 8 bits; start also raised as done is produced.
        run_xfer("mode0", 3, 1'b0, 1'b0, 8, 1'b0, 1'b1);
        // Mode 3 at clk/2, single bit, one IDLE cycle after the previous done.
        run_xfer("mode3", 0, 1'b1, 1'b1, 1, 1'b0, 1'b0);
        // Config changes and start during busy must not affect the transfer.
        run_xfer("chg", 3, 1'b0, 1'b0, 8, 1'b1, 1'b0);
        check("chg new_cpol", 32'(sclk), 32'(1));
        // Other modes for coverage of the strobe table.
        run_xfer("mode1", 1, 1'b0, 1'b1, 5, 1'b0, 1'b0);
        run_xfer("mode2", 2, 1'b1, 1'b0, 3, 1'b0, 1'b0);

        // nbits=0 is ignored.
        cpol  = 1'b0;
        nbits = 6'd0;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("nbits0 busy c=%0d", i), 32'(busy), 32'(0));
            check($sformatf("nbits0 sclk c=%0d", i), 32'(sclk), 32'(0));
        end
        start = 1'b0;
        tick();

        // Reset on the third SCLK edge of an 8-bit mode 0 transfer.
        div   = 8'd3;
        cpol  = 1'b0;
        cpha  = 1'b0;
        nbits = 6'd8;
        start = 1'b1;
        for (int c = 0; c <= 12; c++) sb_q.push_back(model(c, 3, 1'b0, 1'b0, 8));
        tick();
        start = 1'b0;
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) tick();
            e = sb_q.pop_front();
            check($sformatf("prerst c=%0d", c), 32'(observe()), 32'(e));
        end
        rst = 1'b1;
        #1;
        check("async_rst", 32'(observe()), 32'(0));
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("in_rst c=%0d", i), 32'(observe()), 32'(0));
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("after_rst c=%0d", i), 32'(observe()), 32'(0));
        end
        run_xfer("fresh", 3, 1'b0, 1'b0, 8, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
